// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID skid stage.
package if_id_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [31:0] NOP_DEFAULT = '0;

  // Reference layout of one entry at default widths; the RTL packs entries
  // flat as {pc, ir, lane_vld} so the widths can follow the parameters.
  typedef struct packed {
    logic [17:0] pc;
    logic [31:0] ir;
    logic        lane_vld;
  } entry_t;

endpackage

// File: rtl/if_id_entry.sv
// One IF/ID entry register: clear beats load, async active-low reset.
module if_id_entry #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      q <= '0;
    else if (clr)  q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage with valid/ready handshake, 2-entry skid buffer,
// hazard hold, kill/bubble flush and a saturating flush-drop counter.
module if_id_skid_stage
  import if_id_pkg::*;
#(
  parameter int unsigned          PC_SIZE    = 18,
  parameter int unsigned          DATA_SIZE  = 32,
  parameter int unsigned          LANES      = 1,
  parameter int unsigned          FLUSH_MODE = 1,
  parameter logic [DATA_SIZE-1:0] NOP_VALUE  = DATA_SIZE'(NOP_DEFAULT),
  parameter int unsigned          CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_SIZE-1:0]         in_pc,
  input  logic [LANES*DATA_SIZE-1:0] in_ir,
  input  logic [LANES-1:0]           in_lane_vld,
  input  logic                       hold,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_SIZE-1:0]         out_pc,
  output logic [LANES*DATA_SIZE-1:0] out_ir,
  output logic [LANES-1:0]           out_lane_vld,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int unsigned ENT_W = PC_SIZE + LANES*DATA_SIZE + LANES;

  state_t             state, state_nxt;
  logic [ENT_W-1:0]   main_q, skid_q, main_d, in_ent, bubble_ent;
  logic               main_load, main_clr, skid_load, skid_clr;
  logic               in_fire, out_fire;
  logic               main_has, skid_has;
  logic [1:0]         drop_inc;
  logic [CNT_W:0]     drop_sum;

  assign in_ready   = (state != TWO) && !hold;
  assign out_valid  = (state != EMPTY);
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready && !hold;

  assign in_ent     = {in_pc, in_ir, in_lane_vld};
  assign bubble_ent = {in_pc, {LANES{NOP_VALUE}}, {LANES{1'b0}}};
  assign {out_pc, out_ir, out_lane_vld} = main_q;

  if_id_entry #(.W(ENT_W)) u_main (
    .clk(clk), .rst(rst), .load(main_load), .clr(main_clr), .d(main_d), .q(main_q)
  );

  if_id_entry #(.W(ENT_W)) u_skid (
    .clk(clk), .rst(rst), .load(skid_load), .clr(skid_clr), .d(in_ent), .q(skid_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    main_load = 1'b0;
    main_clr  = 1'b0;
    main_d    = in_ent;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (flush) begin
      skid_clr = 1'b1;
      if (FLUSH_MODE == 0) begin
        state_nxt = EMPTY;
        main_clr  = 1'b1;
      end else begin
        state_nxt = ONE;
        main_load = 1'b1;
        main_d    = bubble_ent;
      end
    end else begin
      unique case (state)
        EMPTY: if (in_fire) begin
          state_nxt = ONE;
          main_load = 1'b1;
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            state_nxt = TWO;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        TWO: if (out_fire) begin
          state_nxt = ONE;
          main_load = 1'b1;
          main_d    = skid_q;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Bubbles (lane_vld all zero) are not real packets and are not counted.
  assign main_has = (state != EMPTY) && (|main_q[LANES-1:0]);
  assign skid_has = (state == TWO) && (|skid_q[LANES-1:0]);
  assign drop_inc = {1'b0, main_has} + {1'b0, skid_has} + {1'b0, in_valid};
  assign drop_sum = {1'b0, drop_cnt} + {{(CNT_W-1){1'b0}}, drop_inc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     drop_cnt <= '0;
    else if (flush && drop_sum[CNT_W]) drop_cnt <= '1;
    else if (flush)               drop_cnt <= drop_sum[CNT_W-1:0];
  end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Self-checking bench: two DUTs (bubble and kill flush) against a FIFO reference model.
module tb_if_id_skid_stage;

  localparam int unsigned PCW = 18;
  localparam int unsigned DW  = 32;
  localparam int unsigned LN  = 2;
  localparam int unsigned CW  = 4;
  localparam int unsigned CMAX = 15;

  typedef struct packed {
    logic [PCW-1:0]   pc;
    logic [LN*DW-1:0] ir;
    logic [LN-1:0]    lv;
  } pkt_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, hold = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [PCW-1:0]   in_pc = '0;
  logic [LN*DW-1:0] in_ir = '0;
  logic [LN-1:0]    in_lane_vld = '0;

  logic             rdy1, ov1, rdy0, ov0;
  logic [PCW-1:0]   pc1, pc0;
  logic [LN*DW-1:0] ir1, ir0;
  logic [LN-1:0]    lv1, lv0;
  logic [CW-1:0]    dc1, dc0;

  pkt_t        fifo [2][2];
  int unsigned n [2];
  int unsigned drop [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_id_skid_stage #(
    .PC_SIZE(PCW), .DATA_SIZE(DW), .LANES(LN), .FLUSH_MODE(1), .NOP_VALUE(32'h0), .CNT_W(CW)
  ) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_pc(in_pc), .in_ir(in_ir),
    .in_lane_vld(in_lane_vld), .hold(hold), .flush(flush), .out_valid(ov1), .out_ready(out_ready),
    .out_pc(pc1), .out_ir(ir1), .out_lane_vld(lv1), .drop_cnt(dc1)
  );

  if_id_skid_stage #(
    .PC_SIZE(PCW), .DATA_SIZE(DW), .LANES(LN), .FLUSH_MODE(0), .NOP_VALUE(32'h0), .CNT_W(CW)
  ) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_pc(in_pc), .in_ir(in_ir),
    .in_lane_vld(in_lane_vld), .hold(hold), .flush(flush), .out_valid(ov0), .out_ready(out_ready),
    .out_pc(pc0), .out_ir(ir0), .out_lane_vld(lv0), .drop_cnt(dc0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      n[m] = 0;
      drop[m] = 0;
    end
  endtask

  // FIFO view of the stage: pop on consume, push on accept, flush empties or leaves a bubble.
  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      int unsigned held;
      logic rd, of;
      if (flush) begin
        held = 0;
        if (n[m] >= 1 && fifo[m][0].lv != '0) held++;
        if (n[m] == 2 && fifo[m][1].lv != '0) held++;
        if (in_valid) held++;
        drop[m] = (drop[m] + held > CMAX) ? CMAX : drop[m] + held;
        if (m == 1) begin
          fifo[m][0] = '{pc: in_pc, ir: '0, lv: '0};
          n[m] = 1;
        end else begin
          n[m] = 0;
        end
      end else begin
        rd = (n[m] < 2) && !hold;
        of = (n[m] > 0) && out_ready && !hold;
        if (of) begin
          fifo[m][0] = fifo[m][1];
          n[m]--;
        end
        if (in_valid && rd) begin
          fifo[m][n[m]] = '{pc: in_pc, ir: in_ir, lv: in_lane_vld};
          n[m]++;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("ov1", 64'(ov1), 64'(n[1] > 0));
    chk("ov0", 64'(ov0), 64'(n[0] > 0));
    chk("dc1", 64'(dc1), 64'(drop[1]));
    chk("dc0", 64'(dc0), 64'(drop[0]));
    if (n[1] > 0) begin
      chk("pc1", 64'(pc1), 64'(fifo[1][0].pc));
      chk("ir1", ir1,      fifo[1][0].ir);
      chk("lv1", 64'(lv1), 64'(fifo[1][0].lv));
    end
    if (n[0] > 0) begin
      chk("pc0", 64'(pc0), 64'(fifo[0][0].pc));
      chk("ir0", ir0,      fifo[0][0].ir);
      chk("lv0", 64'(lv0), 64'(fifo[0][0].lv));
    end
  endtask

  // Called just after a falling edge with inputs already set.
  task automatic step();
    #1;
    chk("rdy1", 64'(rdy1), 64'((n[1] < 2) && !hold));
    chk("rdy0", 64'(rdy0), 64'((n[0] < 2) && !hold));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [PCW-1:0] pc, input logic [LN-1:0] lv,
                       input logic h, input logic f, input logic ordy);
    in_valid    = v;
    in_pc       = pc;
    in_ir       = {32'hA500_0000 ^ 32'(pc), 32'h5A00_0000 ^ 32'(pc)};
    in_lane_vld = lv;
    hold        = h;
    flush       = f;
    out_ready   = ordy;
  endtask

  initial begin
    model_reset();
    #12;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_rdy1", 64'(rdy1), 64'd1);
    chk("rst_ov1",  64'(ov1),  64'd0);
    chk("rst_pc1",  64'(pc1),  64'd0);
    chk("rst_dc1",  64'(dc1),  64'd0);
    chk("rst_ov0",  64'(ov0),  64'd0);
    @(negedge clk);

    // streaming with consumer always ready
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 18'(32'h10 + 4*i), 2'b11, 1'b0, 1'b0, 1'b1);
      step();
      chk("stream_pc", 64'(pc1), 64'(32'h10 + 4*i));
    end
    drive(1'b0, '0, 2'b11, 1'b0, 1'b0, 1'b1);
    step();

    // backpressure fills the skid entry
    drive(1'b1, 18'h20, 2'b11, 1'b0, 1'b0, 1'b1); step();
    drive(1'b1, 18'h24, 2'b11, 1'b0, 1'b0, 1'b0); step();
    chk("two_rdy", 64'(rdy1), 64'd0);
    drive(1'b0, '0, 2'b11, 1'b0, 1'b0, 1'b1); step();
    chk("drain_b", 64'(pc1), 64'h24);
    step();

    // hazard hold with a pending packet
    drive(1'b1, 18'h30, 2'b11, 1'b0, 1'b0, 1'b1); step();
    drive(1'b1, 18'h34, 2'b11, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step();
    chk("hold_pc", 64'(pc1), 64'h30);
    hold = 1'b0;
    step();
    chk("after_hold", 64'(pc1), 64'h34);
    drive(1'b0, '0, 2'b11, 1'b0, 1'b0, 1'b1); step();

    // flush over hold while full
    drive(1'b1, 18'h38, 2'b11, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 18'h3C, 2'b11, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 18'h40, 2'b11, 1'b1, 1'b1, 1'b0); step();
    chk("fl_ov1", 64'(ov1), 64'd1);
    chk("fl_pc1", 64'(pc1), 64'h40);
    chk("fl_ir1", ir1, 64'd0);
    chk("fl_lv1", 64'(lv1), 64'd0);
    chk("fl_dc1", 64'(dc1), 64'd3);
    chk("fl_ov0", 64'(ov0), 64'd0);

    // partial lane mask
    drive(1'b1, 18'h44, 2'b01, 1'b0, 1'b0, 1'b1); step();
    chk("lane_vld", 64'(lv1), 64'h1);
    chk("lane1_ir", 64'(ir1[63:32]), 64'(32'hA500_0044));

    // drive the counter into saturation
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 18'(32'h100 + i), 2'b11, 1'b0, 1'b1, 1'b0);
      step();
    end
    chk("sat1", 64'(dc1), 64'(CMAX));
    chk("sat0", 64'(dc0), 64'(CMAX));

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(0, 1)), 18'($urandom), 2'($urandom),
            1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 6),
            1'($urandom_range(0, 99) < 70));
      in_ir = {$urandom, $urandom};
      step();
    end

    // async reset while full
    drive(1'b0, '0, 2'b11, 1'b0, 1'b0, 1'b1); step(); step();
    drive(1'b1, 18'h70, 2'b11, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 18'h74, 2'b11, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, '0, 2'b11, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_ov1", 64'(ov1), 64'd0);
    chk("arst_pc1", 64'(pc1), 64'd0);
    chk("arst_ir1", ir1, 64'd0);
    chk("arst_dc1", 64'(dc1), 64'd0);
    chk("arst_ov0", 64'(ov0), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 18'h80, 2'b11, 1'b0, 1'b0, 1'b1);
    step();
    chk("post_rst_pc", 64'(pc1), 64'h80);
    drive(1'b0, '0, 2'b11, 1'b0, 1'b0, 1'b1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
